// File: rtl/buscaminas_pkg.sv
// Shared board geometry, cell type, placement FSM states and LFSR taps
// for the minesweeper pipeline.
package buscaminas_pkg;

   localparam int unsigned FILAS       = 8;
   localparam int unsigned COLUMNAS    = 8;
   localparam int unsigned ANCHO_CELDA = 9;
   localparam int unsigned BIT_BOMBA   = 8;

   typedef logic [ANCHO_CELDA-1:0] celda_t;

   typedef enum logic [1:0] {
      IDLE,
      LIMPIAR,
      COLOCAR,
      FIN
   } estado_colocador_t;

   // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register:
   // bits 7,5,4,3 are XORed into the new LSB.
   localparam logic [7:0] TAPS_LFSR = 8'hB8;

   // Clamp a requested bomb count into 1..maximo.
   function automatic logic [5:0] limitar_bombas(input logic [5:0] pedido,
                                                 input logic [5:0] maximo);
      logic [5:0] r;
      r = pedido;
      if (pedido == 6'd0)
         r = 6'd1;
      else if (pedido > maximo)
         r = maximo;
      return r;
   endfunction

endpackage

// File: rtl/lfsr_buscaminas.sv
// Free-running 8-bit Fibonacci LFSR (period 255) used to pick candidate cells.
module lfsr_buscaminas
   import buscaminas_pkg::*;
#(
   parameter logic [7:0] SEMILLA = 8'hA5
)
(
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] valor
);

   // Shift left every cycle, feeding back the XOR of the tapped bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         valor <= SEMILLA;
      else
         valor <= {valor[6:0], ^(valor & TAPS_LFSR)};
   end

endmodule

// File: rtl/colocador_bombas.sv
// Bomb placement stage: on start, clears the 8x8 board and drops a clamped
// number of distinct bombs at LFSR-chosen cells, one candidate per clock.
module colocador_bombas
   import buscaminas_pkg::*;
#(
   parameter int unsigned MAX_BOMBAS = 40,
   parameter logic [7:0]  SEMILLA    = 8'hA5
)
(
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic [5:0]                          num_bombas,
   output celda_t [FILAS-1:0][COLUMNAS-1:0]    matriz,
   output logic                                busy,
   output logic                                done,
   output logic [5:0]                          bombas_colocadas
);

   localparam logic [5:0] MAX_B = 6'(MAX_BOMBAS);

   estado_colocador_t estado;
   logic [7:0]        lfsr;
   logic [5:0]        objetivo;
   logic [5:0]        objetivo_sig;
   logic [2:0]        fila_cand;
   logic [2:0]        col_cand;
   logic              lfsr_unused;

   lfsr_buscaminas #(
      .SEMILLA (SEMILLA)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .valor (lfsr)
   );

   // Candidate cell from the low six LFSR bits, and the clamped target.
   always_comb begin
      fila_cand    = lfsr[5:3];
      col_cand     = lfsr[2:0];
      objetivo_sig = limitar_bombas(num_bombas, MAX_B);
   end

   assign lfsr_unused = ^lfsr[7:6];

   // Placement FSM with registered board, counter, busy and done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado           <= IDLE;
         matriz           <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         bombas_colocadas <= '0;
         objetivo         <= '0;
      end else begin
         case (estado)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  objetivo <= objetivo_sig;
                  busy     <= 1'b1;
                  estado   <= LIMPIAR;
               end
            end
            LIMPIAR: begin
               matriz           <= '0;
               bombas_colocadas <= '0;
               estado           <= COLOCAR;
            end
            COLOCAR: begin
               // Occupied candidates are simply skipped; the LFSR moves on.
               if (!matriz[fila_cand][col_cand][BIT_BOMBA]) begin
                  matriz[fila_cand][col_cand][BIT_BOMBA] <= 1'b1;
                  bombas_colocadas <= bombas_colocadas + 6'd1;
                  if (bombas_colocadas + 6'd1 == objetivo) begin
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     estado <= FIN;
                  end
               end
            end
            FIN: begin
               done   <= 1'b0;
               estado <= IDLE;
            end
            default: begin
               estado <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_colocador_bombas.sv
// Bench for colocador_bombas: predicts each board from the LFSR sequence
// and the placement rules, and checks timing of busy/done.
module tb_colocador_bombas;
   import buscaminas_pkg::*;

   localparam int MAXB = 40;
   localparam logic [7:0] SEED = 8'hA5;

   logic                             clk;
   logic                             reset;
   logic                             start;
   logic [5:0]                       num_bombas;
   celda_t [FILAS-1:0][COLUMNAS-1:0] matriz;
   logic                             busy;
   logic                             done;
   logic [5:0]                       bombas_colocadas;

   int errors = 0;
   int checks = 0;
   int ciclo;
   logic [7:0] seq [255];

   typedef struct {
      int n;
      bit repulse;
      int exp_cnt;
   } vec_t;
   vec_t tabla [8];

   colocador_bombas #(
      .MAX_BOMBAS (MAXB),
      .SEMILLA    (SEED)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .num_bombas       (num_bombas),
      .matriz           (matriz),
      .busy             (busy),
      .done             (done),
      .bombas_colocadas (bombas_colocadas)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising edges since reset release; the LFSR value in a cycle is seq[ciclo % 255].
   always @(posedge clk or negedge reset) begin
      if (!reset) ciclo <= 0;
      else        ciclo <= ciclo + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mapa();
      logic [63:0] m;
      for (int f = 0; f < 8; f++)
         for (int c = 0; c < 8; c++)
            m[f*8+c] = matriz[f][c][8];
      return m;
   endfunction

   function automatic int contar();
      return $countones(mapa());
   endfunction

   function automatic int bajos();
      int o;
      o = 0;
      for (int f = 0; f < 8; f++)
         for (int c = 0; c < 8; c++)
            o = o | int'(matriz[f][c][7:0]);
      return o;
   endfunction

   function automatic int clamp(input int n);
      if (n == 0) return 1;
      if (n > MAXB) return MAXB;
      return n;
   endfunction

   task automatic run_vec(input int n, input bit repulse, input int exp_cnt);
      logic [63:0] pred;
      int cnt, k, fin, c, done_at, busy_err, clear_err;
      bit seen;
      logic [5:0] idx;
      @(negedge clk);
      start = 1'b1;
      num_bombas = 6'(n);
      c = ciclo;
      pred = '0;
      cnt = 0;
      k = c + 2;
      while (cnt < exp_cnt) begin
         idx = seq[k % 255][5:0];
         if (!pred[idx]) begin
            pred[idx] = 1'b1;
            cnt++;
         end
         k++;
      end
      fin = k;
      seen = 0;
      done_at = -1;
      busy_err = 0;
      clear_err = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (ciclo == c + 2 && contar() != 0) clear_err++;
         if (busy !== (ciclo < fin)) busy_err++;
         if (done === 1'b1) begin
            seen = 1;
            done_at = ciclo;
         end
         start = repulse && (ciclo < fin);
         if (repulse) num_bombas = 6'($urandom);
      end
      start = 1'b0;
      chk("done_seen", int'(seen), 1);
      chk("done_cycle", done_at - c, fin - c);
      chk("busy_shape", busy_err, 0);
      chk("limpiar", clear_err, 0);
      chk("contador", int'(bombas_colocadas), exp_cnt);
      chk("num_bombas_tablero", contar(), exp_cnt);
      chk64("tablero", mapa(), pred);
      chk("bits_bajos", bajos(), 0);
      @(negedge clk);
      chk("done_pulso", int'(done), 0);
      chk("busy_fin", int'(busy), 0);
   endtask

   initial begin
      logic [7:0] s;
      bit ok;
      s = SEED;
      for (int i = 0; i < 255; i++) begin
         seq[i] = s;
         s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      end

      tabla[0] = '{10, 1'b0, 10};
      tabla[1] = '{0,  1'b0, 1};
      tabla[2] = '{63, 1'b0, 40};
      tabla[3] = '{15, 1'b1, 15};
      tabla[4] = '{20, 1'b0, 20};
      tabla[5] = '{3,  1'b0, 3};
      tabla[6] = '{40, 1'b0, 40};
      tabla[7] = '{41, 1'b0, 40};

      // Reset held with start asserted
      reset = 1'b0;
      start = 1'b1;
      num_bombas = 6'd10;
      repeat (3) @(negedge clk);
      chk("rst_celdas", contar() + bajos(), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_contador", int'(bombas_colocadas), 0);
      start = 1'b0;
      reset = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_celdas", contar(), 0);

      foreach (tabla[i]) run_vec(tabla[i].n, tabla[i].repulse, tabla[i].exp_cnt);

      // Reset in the middle of COLOCAR
      @(negedge clk);
      start = 1'b1;
      num_bombas = 6'd20;
      @(negedge clk);
      start = 1'b0;
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (bombas_colocadas >= 6'd5) ok = 1;
      end
      chk("mid_llego5", int'(ok), 1);
      reset = 1'b0;
      #1;
      chk("mid_celdas", contar(), 0);
      chk("mid_busy", int'(busy), 0);
      chk("mid_contador", int'(bombas_colocadas), 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_sin_reanudar", int'(busy) + contar(), 0);
      run_vec(5, 1'b0, 5);

      // Random counts and random idle gaps
      for (int r = 0; r < 8; r++) begin
         int n, gap;
         n = int'($urandom_range(0, 63));
         gap = int'($urandom_range(0, 20));
         repeat (gap) @(negedge clk);
         run_vec(n, r[0], clamp(n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/colocador_bombas.md
# colocador_bombas

Sequential bomb-placement stage for the 8x8 minesweeper board. On a start pulse it clears the board and places a requested number of distinct bombs at pseudo-random cells using a free-running LFSR, one candidate cell per clock. Its registered board output feeds the adjacent-bomb counter stage directly, so it replaces the switch/random-list/search-and-assign chain.

## Interface
- `MAX_BOMBAS`, default 40: upper clamp on the bomb count; legal range 1..63.
- `SEMILLA`, default 8'hA5: LFSR reset value; must be non-zero.
- `clk`  in  1  single system clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new board; sampled only in IDLE.
- `num_bombas`  in  6  requested bomb count, sampled on the accepted `start`.
- `matriz`  out  [8:0] x [7:0][7:0]  board, indexed `[fila][columna]`; bit 8 = bomb, bits 7:0 = 0.
- `busy`  out  1  high from the cycle after an accepted `start` until `done` is asserted.
- `done`  out  1  one-cycle pulse when the board is complete.
- `bombas_colocadas`  out  6  bombs placed so far; final value is valid while `done` is high.

## Operation
- Reset values (asynchronous, while `reset`=0): every `matriz` cell 9'd0, `busy`=0, `done`=0, `bombas_colocadas`=0, LFSR=`SEMILLA`, state IDLE.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, period 255. It advances every cycle in every state, so user timing of `start` supplies entropy.
- Candidate index = `lfsr[5:0]`: fila = idx[5:3], columna = idx[2:0].
- Target = clamp(`num_bombas`): 0 becomes 1; values above `MAX_BOMBAS` become `MAX_BOMBAS`. The target is latched when `start` is accepted.
- FSM states:
  - IDLE: `start`=1 latches the target and moves to LIMPIAR.
  - LIMPIAR: one cycle. All cells and `bombas_colocadas` are set to 0. Moves to COLOCAR.
  - COLOCAR: each cycle, if candidate cell bit 8 = 0, set it and increment `bombas_colocadas`. If bit 8 = 1, the cycle is skipped. When the increment reaches the target, move to FIN.
  - FIN: `done`=1 for one cycle, `busy` drops, return to IDLE.
- `start` is ignored in LIMPIAR, COLOCAR and FIN; there is no queuing.
- The board holds its last contents in IDLE until the next LIMPIAR or reset.
- Arithmetic: `bombas_colocadas` is 6-bit and never exceeds the target, so it cannot wrap.

## Timing
- `start` sampled in cycle T gives: LIMPIAR in T+1, first placement written at the end of T+2.
- `busy`=1 from T+1 through the last COLOCAR cycle. `done`=1 in the FIN cycle; `busy`=0 in that same cycle.
- Latency bound: every 6-bit value appears at least 3 times per 255-cycle LFSR period, so COLOCAR lasts at most 255 cycles. `done` therefore asserts no later than T+258.
- Best case with no collisions: `done` at T+2+target.
- Reset deasserted mid-operation: nothing resumes. The block starts in IDLE with the board cleared.
- `matriz` changes only on clock edges, at most one cell per cycle. Downstream may sample it freely once `done` has been seen.

## Structure
- Package `buscaminas_pkg` holds:
  - `FILAS`=8, `COLUMNAS`=8, `ANCHO_CELDA`=9, `BIT_BOMBA`=8;
  - typedef `celda_t` (logic [8:0]);
  - FSM enum `estado_colocador_t` {IDLE, LIMPIAR, COLOCAR, FIN};
  - LFSR tap constant.
- One sub-module, `lfsr_buscaminas`: 8-bit LFSR with seed parameter, async active-low reset, always enabled, output `valor[7:0]`.
- Top level contains the FSM, target clamp, counter and board registers.

## Test plan
- Reset: hold `reset`=0 with `start`=1 -> all 64 cells 0, `busy`=0, `done`=0, `bombas_colocadas`=0; no activity after release until `start`.
- `num_bombas`=10, start once -> `done` pulses exactly once by T+258; exactly 10 cells have bit 8 set; bits 7:0 all zero; `bombas_colocadas`=10.
- `num_bombas`=0 -> exactly 1 bomb. `num_bombas`=63 with `MAX_BOMBAS`=40 -> exactly 40 bombs.
- `start` re-pulsed every cycle while `busy` -> single `done`; target unchanged by later `num_bombas` edits.
- Pull `reset` low during COLOCAR (after about 5 bombs) -> board immediately all zero, `busy`=0. A fresh `start` with 5 -> exactly 5 bombs.
- Two back-to-back runs (20 then 3) -> second board has exactly 3 bombs. Waveform shows LIMPIAR clearing the first board one cycle after the accepted `start`.
